four_bit_1x2_demux_reg: RTL and testbench

Registered 4-bit 1-to-2 demultiplexer: the inverse of the 4-bit 2x1 mux. It steers one input word stream to one of two outputs under Select, with a valid/ready handshake on every side. Each output has a one-entry register slot, so the two destinations can back-pressure independently. Per-output saturating delivery counters support bring-up and debug in the combinational-circuits lab datapath.

---
 rtl/four_bit_1x2_demux_reg_pkg.sv | 17 +
 rtl/four_bit_1x2_demux_reg_if.sv | 31 +++
 rtl/four_bit_1x2_demux_reg_slot.sv | 48 ++++
 rtl/four_bit_1x2_demux_reg.sv | 44 ++++
 tb/tb_four_bit_1x2_demux_reg.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/four_bit_1x2_demux_reg_pkg.sv
// four_bit_1x2_demux_reg_pkg: shared slot state encoding and default widths
package four_bit_1x2_demux_reg_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_CNT_WIDTH = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // A slot can take a new word when it is empty or its current word leaves this cycle
    function automatic logic slot_can_load(input slot_state_t state, input logic ready);
        return (state == EMPTY) || ready;
    endfunction

endpackage

// File: rtl/four_bit_1x2_demux_reg_if.sv
// four_bit_1x2_demux_reg_if: input stream plus two output streams and delivery counters
interface four_bit_1x2_demux_reg_if
    import four_bit_1x2_demux_reg_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
    logic [WIDTH-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 select;
    logic [WIDTH-1:0]     out_0;
    logic                 out_0_valid;
    logic                 out_0_ready;
    logic [WIDTH-1:0]     out_1;
    logic                 out_1_valid;
    logic                 out_1_ready;
    logic [CNT_WIDTH-1:0] count_0;
    logic [CNT_WIDTH-1:0] count_1;

    modport master (
        output in_data, in_valid, select, out_0_ready, out_1_ready,
        input  in_ready, out_0, out_0_valid, out_1, out_1_valid, count_0, count_1
    );

    modport slave (
        input  in_data, in_valid, select, out_0_ready, out_1_ready,
        output in_ready, out_0, out_0_valid, out_1, out_1_valid, count_0, count_1
    );

endinterface

// File: rtl/four_bit_1x2_demux_reg_slot.sv
// four_bit_1x2_demux_reg_slot: one-entry output register with handshake and saturating delivery counter
module four_bit_1x2_demux_reg_slot
    import four_bit_1x2_demux_reg_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     d,
    input  logic                 ready,
    output logic [WIDTH-1:0]     q,
    output logic                 valid,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 can_load
);

    slot_state_t state_q, state_d;

    assign valid    = (state_q == FULL);
    assign can_load = slot_can_load(state_q, ready);

    // Slot state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // A load always wins (refill on drain); otherwise a consumed word empties the slot
    always_comb begin
        state_d = state_q;
        state_d = load ? FULL : (ready ? EMPTY : state_q);
    end

    // Data only changes on load, so a stalled word stays put and an empty slot keeps its last word
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= '0;
        else if (load) q <= d;
    end

    // Count delivered words, holding at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                count <= '0;
        else if (valid && ready && count != '1) count <= count + CNT_WIDTH'(1);
    end

endmodule

// File: rtl/four_bit_1x2_demux_reg.sv
// four_bit_1x2_demux_reg: registered 1-to-2 demultiplexer steering one stream to two back-pressured outputs
module four_bit_1x2_demux_reg
    import four_bit_1x2_demux_reg_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input logic                    clk,
    input logic                    rst,
    four_bit_1x2_demux_reg_if.slave bus
);

    logic can_load_0, can_load_1;
    logic accept;

    // Ready looks only at the selected slot, never at in_valid
    assign bus.in_ready = bus.select ? can_load_1 : can_load_0;
    assign accept       = bus.in_valid && bus.in_ready;

    four_bit_1x2_demux_reg_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) slot_0 (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && !bus.select),
        .d        (bus.in_data),
        .ready    (bus.out_0_ready),
        .q        (bus.out_0),
        .valid    (bus.out_0_valid),
        .count    (bus.count_0),
        .can_load (can_load_0)
    );

    four_bit_1x2_demux_reg_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) slot_1 (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && bus.select),
        .d        (bus.in_data),
        .ready    (bus.out_1_ready),
        .q        (bus.out_1),
        .valid    (bus.out_1_valid),
        .count    (bus.count_1),
        .can_load (can_load_1)
    );

endmodule

// File: tb/tb_four_bit_1x2_demux_reg.sv
// tb_four_bit_1x2_demux_reg: scoreboard bench for the registered 1-to-2 demultiplexer
module tb_four_bit_1x2_demux_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    bit full0, full1;
    int cnt0, cnt1;

    four_bit_1x2_demux_reg_if #(.WIDTH(4), .CNT_WIDTH(8)) bus ();

    four_bit_1x2_demux_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        full0 = 0;
        full1 = 0;
        cnt0 = 0;
        cnt1 = 0;
    endtask

    // Drive one cycle's inputs just after a rising edge, check and update the model at the falling edge
    task automatic cycle(input logic v, input logic s, input logic [3:0] d, input logic r0, input logic r1);
        logic exp_rdy;
        bus.in_valid    = v;
        bus.select      = s;
        bus.in_data     = d;
        bus.out_0_ready = r0;
        bus.out_1_ready = r1;
        #4;
        exp_rdy = s ? (!full1 || r1) : (!full0 || r0);
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("valid_0", 32'(bus.out_0_valid), 32'(full0));
        check("valid_1", 32'(bus.out_1_valid), 32'(full1));
        check("count_0", 32'(bus.count_0), 32'(cnt0));
        check("count_1", 32'(bus.count_1), 32'(cnt1));
        if (full0) begin
            check("data_0", 32'(bus.out_0), 32'(q0[0]));
            if (r0) begin
                void'(q0.pop_front());
                full0 = 0;
                if (cnt0 < 255) cnt0++;
            end
        end
        if (full1) begin
            check("data_1", 32'(bus.out_1), 32'(q1[0]));
            if (r1) begin
                void'(q1.pop_front());
                full1 = 0;
                if (cnt1 < 255) cnt1++;
            end
        end
        if (v && exp_rdy) begin
            if (s) begin
                q1.push_back(d);
                full1 = 1;
            end else begin
                q0.push_back(d);
                full0 = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.select      = 1'b0;
        bus.in_data     = 4'h0;
        bus.out_0_ready = 1'b0;
        bus.out_1_ready = 1'b0;
        model_reset();
        #1;
        check("rst_valid_0", 32'(bus.out_0_valid), 32'd0);
        check("rst_valid_1", 32'(bus.out_1_valid), 32'd0);
        check("rst_out_0", 32'(bus.out_0), 32'd0);
        check("rst_out_1", 32'(bus.out_1), 32'd0);
        check("rst_count_0", 32'(bus.count_0), 32'd0);
        check("rst_count_1", 32'(bus.count_1), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'(i), 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 4'(i), 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        check("sweep_count_0", 32'(bus.count_0), 32'd16);
        check("sweep_count_1", 32'(bus.count_1), 32'd16);

        cycle(1'b1, 1'b0, 4'hA, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 4'hB, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 4'h5, 1'b0, 1'b1);
        check("stall_out_0", 32'(bus.out_0), 32'hA);
        check("side_out_1", 32'(bus.out_1), 32'h5);
        cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

        cycle(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'h7, 1'b1, 1'b0);
        check("refill_out_0", 32'(bus.out_0), 32'h7);
        check("refill_valid_0", 32'(bus.out_0_valid), 32'd1);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

        cycle(1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'h6, 1'b0, 1'b0);
        bus.in_valid    = 1'b0;
        bus.out_0_ready = 1'b0;
        bus.out_1_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid_0", 32'(bus.out_0_valid), 32'd0);
        check("arst_valid_1", 32'(bus.out_1_valid), 32'd0);
        check("arst_count_0", 32'(bus.count_0), 32'd0);
        check("arst_count_1", 32'(bus.count_1), 32'd0);
        check("arst_out_0", 32'(bus.out_0), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 4'(i), 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        check("sat_count_1", 32'(bus.count_1), 32'd255);
        check("sat_count_0", 32'(bus.count_0), 32'd0);

        for (int i = 0; i < 10000; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        repeat (3) cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        check("drain_valid_0", 32'(bus.out_0_valid), 32'd0);
        check("drain_valid_1", 32'(bus.out_1_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
